// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers (MIPS E stage).
// mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES busy cycles, and the
// result commits to HI/LO on the last one. mthi/mtlo write HI/LO right away.
// Optional build macro MDU_DIV0_FLAG_EN adds the div0 one-cycle pulse output.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        out_sel,
    input  logic        req,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic        div0
`endif
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        temp_hi, temp_lo;
    logic               div_zero;
    logic               accept, is_long, is_div, commit;
    logic [31:0]        res_hi, res_lo;
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] a_s, b_s;

    // Decode: which ops are valid, which run long, and which are divides
    always_comb begin
        accept  = start && !req && (state == IDLE) && (MDUop >= 4'd1) && (MDUop <= 4'd6);
        is_long = (MDUop >= 4'd1) && (MDUop <= 4'd4);
        is_div  = (MDUop == 4'd3) || (MDUop == 4'd4);
    end

    // Arithmetic: full 64-bit products and guarded 32-bit quotient/remainder
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave a stale value behind and infer a latch.
        res_hi = '0;
        res_lo = '0;
        a_s    = $signed(A);
        b_s    = $signed(B);
        // A sign-extended 64-bit unsigned product has the same low 64 bits as
        // the signed product.
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};
        case (MDUop)
            4'd1: {res_hi, res_lo} = prod_s;
            4'd2: {res_hi, res_lo} = prod_u;
            4'd3: if (B != '0) begin
                res_lo = a_s / b_s;
                res_hi = a_s % b_s;
            end
            4'd4: if (B != '0) begin
                res_lo = A / B;
                res_hi = A % B;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments, so every flop samples
        // pre-edge values no matter how the blocks are ordered.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state and outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (accept && is_long) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch operands' result, count down, commit or move-to HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            temp_hi  <= '0;
            temp_lo  <= '0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            if (accept && is_long) begin
                temp_hi  <= res_hi;
                temp_lo  <= res_lo;
                cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                div_zero <= is_div && (B == '0);
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A divide by zero keeps its full timing but leaves HI/LO alone.
            if (commit && !div_zero) begin
                HI <= temp_hi;
                LO <= temp_lo;
            end
            if (accept && MDUop == 4'd5) HI <= A;
            if (accept && MDUop == 4'd6) LO <= A;
        end
    end

`ifdef MDU_DIV0_FLAG_EN
    // div0: one-cycle pulse after accepting a divide with a zero divisor
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div0 <= 1'b0;
        else        div0 <= accept && is_div && (B == '0);
    end
`endif

    // Read port for mfhi/mflo, straight from the committed registers
    assign out = out_sel ? LO : HI;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against an arithmetic
// model of HI/LO. Build with MDU_DIV0_FLAG_EN defined to also cover div0.
module tb_mdu_hilo;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUop = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_sel = 1'b0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] out, HI, LO;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDUop   (MDUop),
        .A       (A),
        .B       (B),
        .out_sel (out_sel),
        .req     (req),
        .busy    (busy),
        .out     (out),
        .HI      (HI),
        .LO      (LO)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .div0    (div0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare HI, LO and both read selections against the model
    task automatic check_regs(input string tag);
        check({tag, ".HI"}, HI, exp_hi);
        check({tag, ".LO"}, LO, exp_lo);
        out_sel = 1'b0;
        #1 check({tag, ".out_hi"}, out, exp_hi);
        out_sel = 1'b1;
        #1 check({tag, ".out_lo"}, out, exp_lo);
        out_sel = 1'b0;
    endtask

    // Issue one instruction and follow it to completion.
    // inject: during the run, send a stray mthi (must be ignored) and pulse req.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rq, input bit inject);
        logic [31:0]     nh, nl;
        longint          ps;
        longint unsigned pu;
        bit              acc, lng, dz;
        int              cyc, n;
        nh  = exp_hi;
        nl  = exp_lo;
        acc = !rq && (op >= 4'd1) && (op <= 4'd6);
        lng = 1'b0;
        dz  = 1'b0;
        cyc = 0;
        if (acc) begin
            case (op)
                4'd1: begin
                    ps  = longint'(int'(a)) * longint'(int'(b));
                    nh  = ps[63:32];
                    nl  = ps[31:0];
                    lng = 1'b1;
                    cyc = MULT_N;
                end
                4'd2: begin
                    pu  = longint'({32'b0, a}) * longint'({32'b0, b});
                    nh  = pu[63:32];
                    nl  = pu[31:0];
                    lng = 1'b1;
                    cyc = MULT_N;
                end
                4'd3, 4'd4: begin
                    lng = 1'b1;
                    cyc = DIV_N;
                    if (b == 0) dz = 1'b1;
                    else if (op == 4'd3) begin
                        nl = int'(a) / int'(b);
                        nh = int'(a) % int'(b);
                    end else begin
                        nl = a / b;
                        nh = a % b;
                    end
                end
                4'd5: nh = a;
                4'd6: nl = a;
                default: ;
            endcase
        end
        MDUop = op;
        A     = a;
        B     = b;
        req   = rq;
        start = 1'b1;
        tick();
        start = 1'b0;
        req   = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        check({tag, ".div0"}, {31'b0, div0}, {31'b0, dz});
`endif
        if (lng) begin
            n = 0;
            while (busy === 1'b1 && n <= cyc + 2) begin
                check({tag, ".hold_hi"}, HI, exp_hi);
                check({tag, ".hold_lo"}, LO, exp_lo);
`ifdef MDU_DIV0_FLAG_EN
                if (n == 1) check({tag, ".div0_off"}, {31'b0, div0}, 32'd0);
`endif
                if (inject && n == 1) begin
                    start = 1'b1;
                    MDUop = 4'd5;
                    A     = 32'hDEADBEEF;
                end else if (inject && n == 2) begin
                    start = 1'b0;
                    req   = 1'b1;
                end else begin
                    start = 1'b0;
                    req   = 1'b0;
                end
                tick();
                n++;
            end
            start = 1'b0;
            req   = 1'b0;
            check({tag, ".busy_cycles"}, n, cyc);
            if (!dz) begin
                exp_hi = nh;
                exp_lo = nl;
            end
        end else begin
            check({tag, ".no_busy"}, {31'b0, busy}, 32'd0);
            exp_hi = nh;
            exp_lo = nl;
        end
        check_regs(tag);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        bit          rq;

        // Reset state
        #3;
        check("rst.busy", {31'b0, busy}, 32'd0);
        check_regs("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Signed and unsigned multiply
        do_op("mult", 4'd1, 32'h80000000, 32'd2, 1'b0, 1'b0);
        do_op("multu", 4'd2, 32'h80000000, 32'd2, 1'b0, 1'b0);

        // Signed then unsigned divide
        do_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        do_op("divu", 4'd4, 32'd7, 32'd2, 1'b0, 1'b0);

        // Moves to HI/LO and read select
        do_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
        do_op("mtlo", 4'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b0);

        // Divide by zero keeps timing but writes nothing
        do_op("div_by0", 4'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        do_op("divu_by0", 4'd4, 32'd100, 32'd0, 1'b0, 1'b0);

        // Suppressed and invalid starts
        do_op("req_mult", 4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
        do_op("req_mthi", 4'd5, 32'h55555555, 32'd0, 1'b1, 1'b0);
        do_op("op0", 4'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        do_op("op7", 4'd7, 32'd3, 32'd3, 1'b0, 1'b0);
        do_op("op15", 4'd15, 32'd3, 32'd3, 1'b0, 1'b0);

        // Start and req arriving while busy are ignored
        do_op("busy_ignore", 4'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
        do_op("busy_ignore_div", 4'd3, 32'h80000001, 32'hFFFFFFFD, 1'b0, 1'b1);

        // Reset in the middle of a multiply clears everything at once
        do_op("pre_rst", 4'd5, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
        MDUop = 4'd1;
        A     = 32'd1000;
        B     = 32'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.HI", HI, 32'd0);
        check("midrst.LO", LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        do_op("post_rst_multu", 4'd2, 32'd3, 32'd4, 1'b0, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 7) == 0) rb = '0;
            if (op == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            rq = ($urandom_range(0, 9) == 0);
            do_op("rand", op, ra, rb, rq, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case the design wedges a wait
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Receives the start pulse, opcode and HI/LO read select that the D-stage decoder produces and the pipeline carries to E.
- Computes mult/multu/div/divu into HI/LO over fixed latencies and services mthi/mtlo/mfhi/mflo.
- Exports busy to the hazard unit, which stalls any MDU instruction in D while busy or start is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (min 1)
- DIV_CYCLES, 10, busy cycles for div/divu (min 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  E-stage MDU instruction valid this cycle
- MDUop  input  4  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; others = no-op
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- out_sel  input  1  0 = read HI, 1 = read LO
- req  input  1  exception/interrupt flush this cycle; suppresses start
- busy  output  1  multi-cycle operation in progress
- out  output  32  HI or LO per out_sel, combinational from committed registers
- HI  output  32  committed HI
- LO  output  32  committed LO

Behaviour:
- Reset (asynchronous, while reset=0): HI=0, LO=0, busy=0, counter=0, temp regs=0. Any in-flight operation is discarded and HI/LO are not updated.
- States: IDLE, RUN.
- Accept condition: start=1, req=0, state IDLE, MDUop in 1..6. If start=1 with req=1, busy=1 or an invalid MDUop, nothing happens.
- mult: {tempHI,tempLO} = signed 64-bit A*B.
- multu: {tempHI,tempLO} = unsigned 64-bit A*B.
- div: tempLO = A/B, tempHI = A%B, signed, truncation toward zero, remainder takes the sign of A.
- divu: tempLO = A/B, tempHI = A%B, unsigned.
- Accept of ops 1-4: temp regs latch at that edge; counter = MULT_CYCLES or DIV_CYCLES; state goes to RUN; busy=1 starting the next cycle.
- RUN: counter decrements each edge. On the edge where counter==1: HI<=tempHI, LO<=tempLO, busy<=0, state to IDLE.
- busy is high for exactly N cycles after the accept edge. HI/LO keep their old values until the commit edge.
- Divide by zero (ops 3/4, B==0): the operation runs full DIV_CYCLES, keeps busy timing, and HI/LO keep their previous values at commit (no write).
- mthi/mtlo (ops 5/6): HI<=A or LO<=A at the accept edge; busy stays 0; state stays IDLE.
- mfhi/mflo do not use start. out = out_sel ? LO : HI, continuously.
- start while busy=1: ignored. The hazard unit guarantees this never happens; the bench checks that it is ignored anyway.
- req=1 while RUN: no effect, and the operation completes. Only a newly arriving start is suppressed.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN
- Defined: adds output div0 (1 bit, reset 0). div0 is a registered, one-cycle pulse asserted the cycle after the accept of div/divu with B==0.
- Undefined: no div0 port; divide-by-zero behaviour is otherwise identical.

Test Plan:
- Signed mult: A=0x80000000, B=2, MDUop=1, start 1 cycle -> busy high exactly 5 cycles, HI=0xFFFFFFFF, LO=0x00000000 at commit, HI/LO unchanged while busy.
- Unsigned mult: same operands, MDUop=2 -> HI=0x00000001, LO=0x00000000 after 5 cycles.
- Signed div then unsigned div:
  - A=0xFFFFFFF9 (-7), B=2, MDUop=3 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then A=7, B=2, MDUop=4 -> LO=3, HI=1.
- mthi/mtlo and read select: mthi A=0x12345678, mtlo A=0x9ABCDEF0 -> no busy; out=0x12345678 with out_sel=0 and 0x9ABCDEF0 with out_sel=1 on the cycle after each write.
- Divide by zero and ignored starts:
  - div with B=0 -> busy 10 cycles, HI/LO unchanged; with MDU_DIV0_FLAG_EN, div0 pulses one cycle.
  - start with req=1 -> busy stays 0, HI/LO unchanged.
  - Second start during busy -> ignored; result is from the first op.
- Reset mid-operation: reset low on cycle 3 of a mult -> busy=0 and HI=LO=0 immediately, without waiting for clk. After release, a new multu 3*4 gives LO=12, HI=0.
